mlu_stream: RTL and testbench
=============================

# mlu_stream

Pipelined, parametrised mask-lookup unit for the GPU pixel path. It accepts one block of `PIXELS` RGB pixels with a 2-bit-per-pixel mask and two colours, then rewrites the block `LANES` pixels per cycle. The result is handed downstream over a valid/ready handshake. It is the sequential, width-generic successor of the combinational 64-pixel MLU and sits between the tile fetch and tile write-back stages.

## Interface
- `PIXELS`, default 64: pixels per block; must be a multiple of `LANES`.
- `LANES`, default 8: pixels processed per cycle, ≥1.
- `CBITS`, default 4: bits per colour channel, ≥1.
- `clk` in 1: sole clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input block offered.
- `in_ready` out 1: unit can accept a block.
- `in_reds`, `in_greens`, `in_blues` in PIXELS*CBITS each: channel planes; pixel i at bits [(i+1)*CBITS-1 : i*CBITS].
- `in_mask` in 2*PIXELS: pixel i code at bits [2i+1 : 2i].
- `primary`, `secondary` in 3*CBITS each: {R,G,B}, R in the MSBs.
- `out_valid` out 1: result block valid.
- `out_ready` in 1: downstream accepts.
- `out_reds`, `out_greens`, `out_blues` out PIXELS*CBITS each: result planes, same packing as the inputs.
- `busy` out 1: high in BUSY or DONE.

## Operation
- FSM states are IDLE, BUSY and DONE. BEATS = PIXELS/LANES. The beat counter is clog2(BEATS) bits, minimum 1.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture the planes, mask, `primary` and `secondary` into working registers, clear the beat counter, and go to BUSY.
  - Inputs are ignored at all other times.
- BUSY, each cycle:
  - Pixels beat*LANES … beat*LANES+LANES-1 of the working planes are replaced per mask code:
    - 00: keep.
    - 01: primary channel.
    - 10: secondary channel.
    - 11: see Configuration.
  - On beat = BEATS-1, go to DONE. Otherwise increment beat.
- DONE:
  - `out_valid`=1 and the output planes are driven from the working registers.
  - On `out_ready`, go to IDLE.
- `in_ready` = (state==IDLE), decoded from registered state.
- `out_valid` = (state==DONE).
- Outputs hold stable while `out_valid`&&!`out_ready`.
- Colours are the values captured at acceptance; later changes on `primary`/`secondary` have no effect on the block in flight.
- Arithmetic is per channel, CBITS wide, with no cross-channel carry.

## Timing
- Reset:
  - State IDLE, beat 0, working registers 0.
  - `out_valid`=0, `busy`=0, all output planes 0, `in_ready`=1.
- Latency: acceptance at edge N gives `out_valid` high after edge N+BEATS.
- Throughput: one block per BEATS+2 cycles minimum (accept, BEATS beats, handoff). There is no overlap of accept with DONE.
- BEATS=1 (LANES=PIXELS): BUSY lasts one cycle.
- Back-pressure: DONE persists indefinitely with stable data, and `in_ready`=0 throughout.
- Reset asserted mid-BUSY or mid-DONE aborts the block immediately:
  - The block is discarded and `out_valid` drops asynchronously.
  - After release the unit is in IDLE.
- `in_valid` during BUSY/DONE is not consumed. The producer must hold the block until `in_ready`.

## Configuration
- Macro `MLU_BLEND_EN`.
- Defined: mask 11 writes the per-channel blend (old + primary) >> 1. The sum is computed at CBITS+1 bits and truncated, not rounded.
- Undefined: mask 11 behaves as 10 (secondary), matching the legacy MLU. The blend adders are not synthesised.

## Test plan
Defaults: PIXELS=64, LANES=8, CBITS=4, BEATS=8.
- All mask 00, random planes, accept at edge N -> `out_valid` at edge N+8; outputs bit-equal to inputs; `in_ready` low from N+1 until the handoff.
- All mask 01, `primary`=12'hF80 -> every out red 4'hF, green 4'h8, blue 4'h0; `busy` high for 9 cycles with `out_ready` tied 1.
- Mask alternating 10/00 (even pixels 10), `secondary`=12'h3C5, inputs all 4'h1 -> even pixels R3 GC B5, odd pixels R1 G1 B1; also checked with LANES=64 (latency 1) and LANES=1 (latency 64).
- Mask all 11, in red 4'h2, `primary` red 4'h7, `secondary` red 4'hA -> red 4'h4 with `MLU_BLEND_EN`, 4'hA without; red 4'hF + 4'hF -> 4'hF with the macro.
- `out_ready` held 0 for 5 cycles in DONE while a second block is offered -> outputs stable, `in_ready`=0, second block accepted only in the first IDLE cycle after handoff; `primary` changed during BUSY does not alter the first result.
- `reset_n` pulsed low during beat 3 -> `out_valid`=0, `busy`=0, all outputs 0 immediately; `in_ready`=1 after release; the next block completes normally.

Source files
------------

// File: rtl/mlu_stream.sv
// Pipelined mask-lookup unit: accepts a block of PIXELS pixels and rewrites LANES pixels per beat.
// Optional feature: define MLU_BLEND_EN to make mask code 11 blend (old + primary) >> 1.

module mlu_lane #(
  parameter int CBITS = 4
) (
  input  logic [1:0]         code,
  input  logic [3*CBITS-1:0] old_px,
  input  logic [3*CBITS-1:0] pri,
  input  logic [3*CBITS-1:0] sec,
  output logic [3*CBITS-1:0] new_px
);
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CBITS-1:0] o, p, s, n;
    assign o = old_px[c*CBITS +: CBITS];
    assign p = pri[c*CBITS +: CBITS];
    assign s = sec[c*CBITS +: CBITS];
`ifdef MLU_BLEND_EN
    // Sum at CBITS+1 so the carry survives into the halved result.
    logic [CBITS:0] sum;
    assign sum = {1'b0, o} + {1'b0, p};
    always_comb begin
      n = o;
      case (code)
        2'b00: n = o;
        2'b01: n = p;
        2'b10: n = s;
        2'b11: n = sum[CBITS:1];
        default: n = o;
      endcase
    end
`else
    always_comb begin
      n = o;
      case (code)
        2'b00:        n = o;
        2'b01:        n = p;
        2'b10, 2'b11: n = s;
        default:      n = o;
      endcase
    end
`endif
    assign new_px[c*CBITS +: CBITS] = n;
  end
endmodule

module mlu_stream #(
  parameter int PIXELS = 64,
  parameter int LANES  = 8,
  parameter int CBITS  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIXELS*CBITS-1:0]  in_reds,
  input  logic [PIXELS*CBITS-1:0]  in_greens,
  input  logic [PIXELS*CBITS-1:0]  in_blues,
  input  logic [2*PIXELS-1:0]      in_mask,
  input  logic [3*CBITS-1:0]       primary,
  input  logic [3*CBITS-1:0]       secondary,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIXELS*CBITS-1:0]  out_reds,
  output logic [PIXELS*CBITS-1:0]  out_greens,
  output logic [PIXELS*CBITS-1:0]  out_blues,
  output logic                     busy
);
  localparam int BEATS = PIXELS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PXW   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int CW    = 3 * CBITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [PIXELS-1:0][CBITS-1:0] plane_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  plane_t                 r_q, g_q, b_q, r_d, g_d, b_d;
  logic [PIXELS-1:0][1:0] mask_q, mask_d;
  logic [CW-1:0]          pri_q, pri_d, sec_q, sec_d;
  logic                   in_ready_q, out_valid_q, busy_q;

  logic [LANES-1:0][CW-1:0]  old_px, new_px;
  logic [LANES-1:0][1:0]     code;
  logic [LANES-1:0][PXW-1:0] pix;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign pix[l]    = PXW'(int'(beat_q) * LANES + l);
    assign old_px[l] = {r_q[pix[l]], g_q[pix[l]], b_q[pix[l]]};
    assign code[l]   = mask_q[pix[l]];
    mlu_lane #(.CBITS(CBITS)) u_lane (
      .code   (code[l]),
      .old_px (old_px[l]),
      .pri    (pri_q),
      .sec    (sec_q),
      .new_px (new_px[l])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    mask_d  = mask_q;
    pri_d   = pri_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: if (in_valid) begin
        r_d     = in_reds;
        g_d     = in_greens;
        b_d     = in_blues;
        mask_d  = in_mask;
        pri_d   = primary;
        sec_d   = secondary;
        beat_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++)
          {r_d[pix[l]], g_d[pix[l]], b_d[pix[l]]} = new_px[l];
        if (beat_q == BW'(BEATS - 1)) state_d = DONE;
        else                          beat_d  = beat_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      mask_q      <= '0;
      pri_q       <= '0;
      sec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      mask_q      <= mask_d;
      pri_q       <= pri_d;
      sec_q       <= sec_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_reds   = out_valid_q ? r_q : '0;
  assign out_greens = out_valid_q ? g_q : '0;
  assign out_blues  = out_valid_q ? b_q : '0;
endmodule

// File: tb/tb_mlu_stream.sv
// Bench for mlu_stream: table vectors, model-scored random blocks, back-pressure,
// mid-block reset and the LANES=64 / LANES=1 latency variants.
module tb_mlu_stream;
  localparam int P  = 64;
  localparam int C  = 4;
  localparam int PW = P * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_v64, in_v1, out_ready, or64, or1;
  logic [PW-1:0] in_reds, in_greens, in_blues;
  logic [2*P-1:0] in_mask;
  logic [11:0]   primary, secondary;

  logic          in_ready, out_valid, busy;
  logic [PW-1:0] out_reds, out_greens, out_blues;
  logic          rdy64, ov64, busy64;
  logic [PW-1:0] r64, g64, b64;
  logic          rdy1, ov1, busy1;
  logic [PW-1:0] r1, g1, b1;

  mlu_stream #(.PIXELS(P), .LANES(8), .CBITS(C)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reds(in_reds), .in_greens(in_greens), .in_blues(in_blues), .in_mask(in_mask),
    .primary(primary), .secondary(secondary), .out_valid(out_valid), .out_ready(out_ready),
    .out_reds(out_reds), .out_greens(out_greens), .out_blues(out_blues), .busy(busy));

  mlu_stream #(.PIXELS(P), .LANES(64), .CBITS(C)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_v64), .in_ready(rdy64),
    .in_reds(in_reds), .in_greens(in_greens), .in_blues(in_blues), .in_mask(in_mask),
    .primary(primary), .secondary(secondary), .out_valid(ov64), .out_ready(or64),
    .out_reds(r64), .out_greens(g64), .out_blues(b64), .busy(busy64));

  mlu_stream #(.PIXELS(P), .LANES(1), .CBITS(C)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_v1), .in_ready(rdy1),
    .in_reds(in_reds), .in_greens(in_greens), .in_blues(in_blues), .in_mask(in_mask),
    .primary(primary), .secondary(secondary), .out_valid(ov1), .out_ready(or1),
    .out_reds(r1), .out_greens(g1), .out_blues(b1), .busy(busy1));

  typedef struct { logic [PW-1:0] r, g, b; } exp_t;
  typedef struct {
    logic [1:0]  me, mo;
    logic [11:0] in_px, pri, sec, exp_e, exp_o;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[7];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [PW-1:0] r, g, b, input logic [2*P-1:0] m,
                                 input logic [11:0] p, s);
    exp_t e;
    for (int i = 0; i < P; i++) begin
      logic [11:0] o, n;
      o = {r[i*C +: C], g[i*C +: C], b[i*C +: C]};
      case (m[2*i +: 2])
        2'b00: n = o;
        2'b01: n = p;
        2'b10: n = s;
        default: begin
`ifdef MLU_BLEND_EN
          for (int ch = 0; ch < 3; ch++) begin
            logic [4:0] t;
            t = {1'b0, o[ch*4 +: 4]} + {1'b0, p[ch*4 +: 4]};
            n[ch*4 +: 4] = t[4:1];
          end
`else
          n = s;
`endif
        end
      endcase
      e.r[i*C +: C] = n[11:8];
      e.g[i*C +: C] = n[7:4];
      e.b[i*C +: C] = n[3:0];
    end
    return e;
  endfunction

  task automatic set_uniform(input logic [11:0] px, input logic [1:0] me, mo);
    for (int i = 0; i < P; i++) begin
      in_reds[i*C +: C]   = px[11:8];
      in_greens[i*C +: C] = px[7:4];
      in_blues[i*C +: C]  = px[3:0];
      in_mask[2*i +: 2]   = (i % 2 == 0) ? me : mo;
    end
  endtask

  function automatic exp_t even_odd(input logic [11:0] pe, po);
    exp_t e;
    for (int i = 0; i < P; i++) begin
      e.r[i*C +: C] = (i % 2 == 0) ? pe[11:8] : po[11:8];
      e.g[i*C +: C] = (i % 2 == 0) ? pe[7:4]  : po[7:4];
      e.b[i*C +: C] = (i % 2 == 0) ? pe[3:0]  : po[3:0];
    end
    return e;
  endfunction

  task automatic set_random(input bit zero_mask);
    for (int w = 0; w < PW / 32; w++) begin
      in_reds[w*32 +: 32]   = $urandom();
      in_greens[w*32 +: 32] = $urandom();
      in_blues[w*32 +: 32]  = $urandom();
    end
    for (int w = 0; w < 2 * P / 32; w++) in_mask[w*32 +: 32] = zero_mask ? 32'h0 : $urandom();
  endtask

  // Leaves the bench at the negedge right after the accepting edge.
  task automatic do_accept(input string nm);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, PW'(in_ready), PW'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_result(input string nm, input int exp_lat);
    int   lat = 0;
    logic rdy_seen = 1'b0;
    exp_t e;
    while (!out_valid && lat < 300) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    chk({nm, "_lat"}, PW'(lat), PW'(exp_lat));
    chk({nm, "_inrdy_low"}, PW'(rdy_seen), PW'(0));
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: got empty scoreboard want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_r"}, out_reds, e.r);
      chk({nm, "_g"}, out_greens, e.g);
      chk({nm, "_b"}, out_blues, e.b);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_ov_drop"}, PW'(out_valid), PW'(0));
    chk({nm, "_inrdy_back"}, PW'(in_ready), PW'(1));
  endtask

  initial begin
    exp_t ea, eb;
    int   bn, l8, l64, l1;
    logic [11:0] pri_b;

    tv[0] = '{me:2'b00, mo:2'b00, in_px:12'h123, pri:12'hF80, sec:12'h3C5, exp_e:12'h123, exp_o:12'h123};
    tv[1] = '{me:2'b01, mo:2'b01, in_px:12'h123, pri:12'hF80, sec:12'h3C5, exp_e:12'hF80, exp_o:12'hF80};
    tv[2] = '{me:2'b10, mo:2'b00, in_px:12'h111, pri:12'hF80, sec:12'h3C5, exp_e:12'h3C5, exp_o:12'h111};
    tv[5] = '{me:2'b01, mo:2'b10, in_px:12'h000, pri:12'h5A3, sec:12'hC3C, exp_e:12'h5A3, exp_o:12'hC3C};
`ifdef MLU_BLEND_EN
    tv[3] = '{me:2'b11, mo:2'b11, in_px:12'h222, pri:12'h777, sec:12'hAAA, exp_e:12'h444, exp_o:12'h444};
    tv[4] = '{me:2'b11, mo:2'b11, in_px:12'hFFF, pri:12'hFFF, sec:12'h000, exp_e:12'hFFF, exp_o:12'hFFF};
    tv[6] = '{me:2'b11, mo:2'b00, in_px:12'h369, pri:12'hACF, sec:12'h0F0, exp_e:12'h69C, exp_o:12'h369};
`else
    tv[3] = '{me:2'b11, mo:2'b11, in_px:12'h222, pri:12'h777, sec:12'hAAA, exp_e:12'hAAA, exp_o:12'hAAA};
    tv[4] = '{me:2'b11, mo:2'b11, in_px:12'hFFF, pri:12'hFFF, sec:12'h000, exp_e:12'h000, exp_o:12'h000};
    tv[6] = '{me:2'b11, mo:2'b00, in_px:12'h369, pri:12'hACF, sec:12'h0F0, exp_e:12'h0F0, exp_o:12'h369};
`endif

    reset_n = 1'b0;
    {in_valid, in_v64, in_v1, out_ready, or64, or1} = '0;
    in_reds = '0; in_greens = '0; in_blues = '0; in_mask = '0;
    primary = '0; secondary = '0;
    #12;
    chk("rst_ov", PW'(out_valid), PW'(0));
    chk("rst_busy", PW'(busy), PW'(0));
    chk("rst_inrdy", PW'(in_ready), PW'(1));
    chk("rst_r", out_reds, '0);
    chk("rst_g", out_greens, '0);
    chk("rst_b", out_blues, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      set_uniform(tv[k].in_px, tv[k].me, tv[k].mo);
      primary = tv[k].pri; secondary = tv[k].sec;
      sbq.push_back(even_odd(tv[k].exp_e, tv[k].exp_o));
      do_accept($sformatf("tv%0d", k));
      do_result($sformatf("tv%0d", k), 8);
    end

    for (int k = 0; k < 3; k++) begin
      set_random(k == 0);
      primary = 12'($urandom()); secondary = 12'($urandom());
      if (k == 0) sbq.push_back('{r:in_reds, g:in_greens, b:in_blues});
      else        sbq.push_back(model(in_reds, in_greens, in_blues, in_mask, primary, secondary));
      do_accept($sformatf("rnd%0d", k));
      do_result($sformatf("rnd%0d", k), 8);
    end

    // All-primary block with out_ready tied high: busy spans BEATS+1 cycles.
    set_random(1'b0);
    in_mask = {P{2'b01}};
    primary = 12'hF80;
    ea = even_odd(12'hF80, 12'hF80);
    out_ready = 1'b1;
    chk("b9_ready", PW'(in_ready), PW'(1));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bn = 0; l8 = 0;
    for (int t = 0; t < 20; t++) begin
      if (busy) bn++;
      if (out_valid && l8 == 0) begin
        l8 = t;
        chk("b9_r", out_reds, ea.r);
        chk("b9_g", out_greens, ea.g);
        chk("b9_b", out_blues, ea.b);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b9_busy_cycles", PW'(bn), PW'(9));
    chk("b9_lat", PW'(l8), PW'(8));

    // Back-pressure: hold DONE while offering a second block; colour change mid-block.
    set_random(1'b0);
    primary = 12'h5E1; secondary = 12'h93C;
    ea = model(in_reds, in_greens, in_blues, in_mask, primary, secondary);
    do_accept("bpA");
    primary = 12'h0AF;
    l8 = 0;
    while (!out_valid && l8 < 300) begin @(negedge clk); l8++; end
    chk("bpA_lat", PW'(l8), PW'(8));
    set_random(1'b0);
    pri_b = primary;
    eb = model(in_reds, in_greens, in_blues, in_mask, pri_b, secondary);
    in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("bpA_hold_r%0d", t), out_reds, ea.r);
      chk($sformatf("bpA_hold_g%0d", t), out_greens, ea.g);
      chk($sformatf("bpA_hold_b%0d", t), out_blues, ea.b);
      chk($sformatf("bpA_hold_inrdy%0d", t), PW'(in_ready), PW'(0));
      chk($sformatf("bpA_hold_ov%0d", t), PW'(out_valid), PW'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ov", PW'(out_valid), PW'(0));
    chk("bp_idle_inrdy", PW'(in_ready), PW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bpB_taken_inrdy", PW'(in_ready), PW'(0));
    chk("bpB_taken_busy", PW'(busy), PW'(1));
    sbq.push_back(eb);
    do_result("bpB", 8);

    // Even pixels secondary, odd kept, on all three lane widths at once.
    set_uniform(12'h111, 2'b10, 2'b00);
    secondary = 12'h3C5; primary = 12'hF80;
    sbq.push_back(even_odd(12'h3C5, 12'h111));
    chk("w_rdy64", PW'(rdy64), PW'(1));
    chk("w_rdy1", PW'(rdy1), PW'(1));
    in_valid = 1'b1; in_v64 = 1'b1; in_v1 = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_v64 = 1'b0; in_v1 = 1'b0;
    l8 = -1; l64 = -1; l1 = -1;
    for (int t = 0; t < 120; t++) begin
      if (out_valid && l8 < 0) l8 = t;
      if (ov64 && l64 < 0) l64 = t;
      if (ov1 && l1 < 0) l1 = t;
      if (l8 >= 0 && l64 >= 0 && l1 >= 0) break;
      @(negedge clk);
    end
    chk("w8_lat", PW'(l8), PW'(8));
    chk("w64_lat", PW'(l64), PW'(1));
    chk("w1_lat", PW'(l1), PW'(64));
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL w_sb: got empty scoreboard want entry");
    end else begin
      ea = sbq.pop_front();
      chk("w8_r", out_reds, ea.r);   chk("w8_g", out_greens, ea.g); chk("w8_b", out_blues, ea.b);
      chk("w64_r", r64, ea.r);       chk("w64_g", g64, ea.g);       chk("w64_b", b64, ea.b);
      chk("w1_r", r1, ea.r);         chk("w1_g", g1, ea.g);         chk("w1_b", b1, ea.b);
    end
    out_ready = 1'b1; or64 = 1'b1; or1 = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; or64 = 1'b0; or1 = 1'b0;
    chk("w_ov_drop", PW'({out_valid, ov64, ov1}), PW'(0));

    // Reset pulsed during beat 3 aborts the block.
    set_random(1'b0);
    do_accept("rstm");
    repeat (3) @(negedge clk);
    chk("rstm_busy_pre", PW'(busy), PW'(1));
    reset_n = 1'b0;
    #1;
    chk("rstm_ov", PW'(out_valid), PW'(0));
    chk("rstm_busy", PW'(busy), PW'(0));
    chk("rstm_r", out_reds, '0);
    chk("rstm_g", out_greens, '0);
    chk("rstm_b", out_blues, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rstm_inrdy", PW'(in_ready), PW'(1));
    @(negedge clk);
    set_random(1'b0);
    primary = 12'h7B2; secondary = 12'h1D4;
    sbq.push_back(model(in_reds, in_greens, in_blues, in_mask, primary, secondary));
    do_accept("post");
    do_result("post", 8);

    chk("sb_empty", PW'(sbq.size()), PW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
